// File: rtl/tri_cpu.sv
// Tiny multi-cycle CPU with three-operand add/multiply-accumulate instructions.
// Each instruction takes FETCH then EXEC; writes commit on the EXEC edge.
module tri_cpu #(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  input  logic [4:0]                    dbg_raddr,
  output logic [XLEN-1:0]               dbg_rdata,
  output logic                          busy,
  output logic                          done,
  output logic                          illegal,
  output logic [XLEN-1:0]               result_out,
  output logic [15:0]                   retired
);
  localparam int AW  = $clog2(IMEM_DEPTH);
  localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_TRIADD = 8'hAA;
  localparam logic [7:0] OP_TRIMAC = 8'hAB;
  localparam logic [7:0] OP_LI     = 8'hAC;
  localparam logic [7:0] OP_ST     = 8'hAD;
  localparam logic [7:0] OP_HALT   = 8'hFF;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  typedef struct packed {
    logic [7:0] op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rs3;
    logic [3:0] pad;
  } instr_t;

  state_t          state;
  instr_t          ir;
  logic [AW-1:0]   pc;
  logic [31:0]     imem [IMEM_DEPTH];
  logic [XLEN-1:0] dmem [DMEM_DEPTH];
  logic [XLEN-1:0] xr   [32];

  logic [13:0]     imm14;
  logic [XLEN-1:0] op_a, op_b, op_c, alu;
  logic            wr_rf, wr_dm, legal, is_halt, idle_like;

  assign imm14     = {ir.rs2, ir.rs3, ir.pad};
  assign idle_like = (state == IDLE) || (state == HALT);

  // x0 is hardwired to zero on every read path
  assign op_a      = (ir.rs1 == 5'd0)    ? '0 : xr[ir.rs1];
  assign op_b      = (ir.rs2 == 5'd0)    ? '0 : xr[ir.rs2];
  assign op_c      = (ir.rs3 == 5'd0)    ? '0 : xr[ir.rs3];
  assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : xr[dbg_raddr];

  always_comb begin
    alu     = '0;
    wr_rf   = 1'b0;
    wr_dm   = 1'b0;
    legal   = 1'b1;
    is_halt = 1'b0;
    case (ir.op)
      OP_NOP:    ;
      OP_TRIADD: begin alu = op_a + op_b + op_c; wr_rf = 1'b1; end
      OP_TRIMAC: begin alu = op_a * op_b + op_c; wr_rf = 1'b1; end
      OP_LI:     begin alu = XLEN'($signed(imm14)); wr_rf = 1'b1; end
      OP_ST:     begin alu = op_a; wr_dm = 1'b1; end
      OP_HALT:   is_halt = 1'b1;
      default:   legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= '0;
      ir         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
      result_out <= '0;
      retired    <= '0;
      for (int i = 0; i < 32; i++) xr[i] <= '0;
    end else begin
      case (state)
        IDLE, HALT: if (start) begin
          state   <= FETCH;
          busy    <= 1'b1;
          done    <= 1'b0;
          pc      <= '0;
          retired <= '0;
          illegal <= 1'b0;
        end
        FETCH: begin
          ir    <= imem[pc];
          state <= EXEC;
        end
        EXEC: begin
          if (!legal || is_halt) begin
            state   <= HALT;
            busy    <= 1'b0;
            done    <= 1'b1;
            illegal <= !legal;
          end else begin
            retired <= retired + 16'd1;
            if (wr_rf || wr_dm) result_out <= alu;
            if (wr_rf && ir.rd != 5'd0) xr[ir.rd] <= alu;
            // Falling off the end of imem is an error, never a wrap to 0
            if (pc == AW'(IMEM_DEPTH - 1)) begin
              state   <= HALT;
              busy    <= 1'b0;
              done    <= 1'b1;
              illegal <= 1'b1;
            end else begin
              pc    <= pc + 1'b1;
              state <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memories hold their contents across reset
  always_ff @(posedge clk) begin
    if (!rst && imem_we && idle_like) imem[imem_waddr] <= imem_wdata;
    if (!rst && state == EXEC && wr_dm) dmem[imm14[DAW-1:0]] <= alu;
  end

endmodule

// File: tb/tb_tri_cpu.sv
// Scoreboard bench for tri_cpu: a stimulus process runs programs and queues the
// interpreter's predicted outcome; a monitor checks each run when done rises.
module tb_tri_cpu;
  typedef struct packed {
    logic              snap;
    logic [31:0]       res;
    logic [15:0]       ret;
    logic              ill;
    logic [31:0]       cyc;
    logic [31:0][31:0] regs;
    logic [15:0]       dmv;
    logic [15:0][31:0] dm;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        st [2];
  logic        we [2];
  logic [3:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg0, res0;
  logic [7:0]  dbg1, res1;
  logic [31:0] dbg_w [2];
  logic [31:0] res_w [2];
  logic        busy_w [2];
  logic        done_w [2];
  logic        ill_w [2];
  logic [15:0] ret_w [2];

  int checks = 0, failures = 0, mon_cnt = 0;
  int cnt [2];
  int snap_req [2];
  int snap_seen [2];
  bit pbusy [2];
  bit pdone [2];
  exp_t q0[$], q1[$];

  // reference model state
  longint unsigned mx [2][32];
  logic [31:0]     mimem [2][16];
  logic [31:0]     md [2][16];
  logic [15:0]     mdv [2];
  logic [31:0]     mres [2];
  logic [31:0]     prog[$];

  always #5 clk = ~clk;

  assign dbg_w[0] = dbg0;
  assign dbg_w[1] = {24'd0, dbg1};
  assign res_w[0] = res0;
  assign res_w[1] = {24'd0, res1};

  tri_cpu #(.XLEN(32), .IMEM_DEPTH(16), .DMEM_DEPTH(16)) dut0 (
    .clk(clk), .rst(rst), .start(st[0]), .imem_we(we[0]), .imem_waddr(waddr),
    .imem_wdata(wdata), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg0), .busy(busy_w[0]),
    .done(done_w[0]), .illegal(ill_w[0]), .result_out(res0), .retired(ret_w[0]));

  tri_cpu #(.XLEN(8), .IMEM_DEPTH(4), .DMEM_DEPTH(16)) dut1 (
    .clk(clk), .rst(rst), .start(st[1]), .imem_we(we[1]), .imem_waddr(waddr[1:0]),
    .imem_wdata(wdata), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg1), .busy(busy_w[1]),
    .done(done_w[1]), .illegal(ill_w[1]), .result_out(res1), .retired(ret_w[1]));

  function automatic int xl(input int d); return (d == 0) ? 32 : 8; endfunction
  function automatic int id(input int d); return (d == 0) ? 16 : 4; endfunction

  function automatic logic [31:0] enc(input logic [7:0] op, input logic [4:0] rd,
                                      input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    return {op, rd, a, b, c, 4'h0};
  endfunction
  function automatic logic [31:0] li(input logic [4:0] rd, input int imm);
    logic [13:0] t = 14'(imm);
    return {8'hAC, rd, 5'd0, t};
  endfunction
  function automatic logic [31:0] sti(input logic [4:0] rs, input int addr);
    logic [13:0] t = 14'(addr);
    return {8'hAD, 5'd0, rs, t};
  endfunction

  function automatic logic [31:0] rnd_instr();
    int r = $urandom_range(0, 99);
    logic [4:0] rd = 5'($urandom), a = 5'($urandom), b = 5'($urandom), c = 5'($urandom);
    if (r < 10) return 32'h0;
    if (r < 35) return enc(8'hAA, rd, a, b, c);
    if (r < 55) return enc(8'hAB, rd, a, b, c);
    if (r < 80) return li(rd, int'($urandom_range(0, 16383)));
    if (r < 92) return sti(a, int'($urandom_range(0, 16383)));
    if (r < 96) return 32'hFF00_0000;
    return {8'($urandom_range(1, 8'h9F)), 24'($urandom)};
  endfunction

  // ---------------- reference interpreter ----------------
  task automatic model_run(input int d, output exp_t e);
    longint unsigned m, a, b, c, v;
    int pc, cyc, ret, imm;
    bit ill, wr;
    logic [31:0] w;
    m = (64'd1 << xl(d)) - 64'd1;
    pc = 0; cyc = 0; ret = 0; ill = 0; v = 0;
    forever begin
      w = mimem[d][pc];
      cyc += 2;
      a = mx[d][w[18:14]]; b = mx[d][w[13:9]]; c = mx[d][w[8:4]];
      imm = int'(w[13:0]);
      if (imm >= 8192) imm -= 16384;
      wr = 1;
      if (w[31:24] == 8'hFF) break;
      case (w[31:24])
        8'h00: wr = 0;
        8'hAA: v = (a + b + c) & m;
        8'hAB: v = (a * b + c) & m;
        8'hAC: v = longint'(imm) & m;
        8'hAD: begin wr = 0; md[d][w[3:0]] = a[31:0]; mdv[d][w[3:0]] = 1'b1; mres[d] = a[31:0]; end
        default: ill = 1;
      endcase
      if (ill) break;
      if (wr) begin
        mres[d] = v[31:0];
        if (w[23:19] != 5'd0) mx[d][w[23:19]] = v;
      end
      ret++;
      if (pc == id(d) - 1) begin ill = 1; break; end
      pc++;
    end
    e = '0;
    e.res = mres[d]; e.ret = 16'(ret); e.ill = ill; e.cyc = 32'(cyc);
    for (int i = 0; i < 32; i++) e.regs[i] = mx[d][i][31:0];
    e.dmv = mdv[d];
    for (int i = 0; i < 16; i++) e.dm[i] = md[d][i];
  endtask

  // ---------------- monitor ----------------
  task automatic chk(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL dut%0d %s: got %0h want %0h", d, name, act, exp);
    end
  endtask

  task automatic compare(input int d, input exp_t e);
    if (e.snap) begin
      chk(d, "busy_idle", 32'(busy_w[d]), 32'd0);
      chk(d, "done_idle", 32'(done_w[d]), 32'd0);
    end else begin
      chk(d, "cycles", 32'(cnt[d]), e.cyc);
    end
    chk(d, "result_out", res_w[d], e.res);
    chk(d, "retired", 32'(ret_w[d]), 32'(e.ret));
    chk(d, "illegal", 32'(ill_w[d]), 32'(e.ill));
    for (int i = 0; i < 32; i++) begin
      dbg_raddr = 5'(i);
      #1;
      chk(d, $sformatf("x%0d", i), dbg_w[d], e.regs[i]);
    end
    if (d == 0)
      for (int i = 0; i < 16; i++)
        if (e.dmv[i]) chk(d, $sformatf("dmem%0d", i), dut0.dmem[i], e.dm[i]);
  endtask

  initial begin
    exp_t e;
    dbg_raddr = 5'd0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (busy_w[d] === 1'b1 && !pbusy[d]) begin
          cnt[d] = 1;
          chk(d, "start_clears_illegal", 32'(ill_w[d]), 32'd0);
          chk(d, "start_clears_retired", 32'(ret_w[d]), 32'd0);
        end else if (busy_w[d] === 1'b1) begin
          cnt[d]++;
        end
        if ((done_w[d] === 1'b1 && !pdone[d]) || snap_req[d] != snap_seen[d]) begin
          if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            checks++; failures++;
            $display("FAIL dut%0d scoreboard: got an outcome with no expectation queued", d);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            compare(d, e);
          end
          if (snap_req[d] != snap_seen[d]) snap_seen[d]++;
          mon_cnt++;
        end
        pbusy[d] = (busy_w[d] === 1'b1);
        pdone[d] = (done_w[d] === 1'b1);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(); @(posedge clk); #1; endtask

  task automatic wait_mon(input int target);
    for (int i = 0; i < 2000; i++) begin
      if (mon_cnt >= target) return;
      @(posedge clk);
    end
    $display("FAIL timeout: monitor count %0d want %0d", mon_cnt, target);
    $fatal(1, "bench timeout");
  endtask

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic do_rst();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++) mx[d][i] = 0;
      mres[d] = '0;
    end
  endtask

  task automatic snap(input int d);
    exp_t e;
    int target = mon_cnt + 1;
    e = '0;
    e.snap = 1'b1; e.res = mres[d];
    for (int i = 0; i < 32; i++) e.regs[i] = mx[d][i][31:0];
    e.dmv = mdv[d];
    for (int i = 0; i < 16; i++) e.dm[i] = md[d][i];
    push(d, e);
    snap_req[d]++;
    wait_mon(target);
  endtask

  task automatic set_prog(input int d);
    for (int i = 0; i < id(d); i++) mimem[d][i] = (i < prog.size()) ? prog[i] : 32'h0;
  endtask

  task automatic load_all(input int d, input bit skip0);
    for (int i = skip0 ? 1 : 0; i < id(d); i++) begin
      we[d] = 1'b1; waddr = 4'(i); wdata = mimem[d][i];
      tick();
      we[d] = 1'b0;
    end
  endtask

  task automatic run(input int d, input bit ld0_with_start, input bit poke);
    exp_t e;
    int target = mon_cnt + 1;
    model_run(d, e);
    push(d, e);
    if (ld0_with_start) begin we[d] = 1'b1; waddr = 4'd0; wdata = mimem[d][0]; end
    st[d] = 1'b1;
    tick();
    st[d] = 1'b0; we[d] = 1'b0;
    if (poke && e.cyc > 6) begin
      // start and program writes while busy must be ignored
      tick(); tick();
      st[d] = 1'b1; we[d] = 1'b1;
      waddr = 4'($urandom_range(0, id(d) - 1)); wdata = $urandom;
      tick();
      st[d] = 1'b0; we[d] = 1'b0;
    end
    wait_mon(target);
  endtask

  task automatic program_run(input int d, input bit ld0_with_start, input bit poke);
    set_prog(d);
    load_all(d, ld0_with_start);
    run(d, ld0_with_start, poke);
  endtask

  initial begin
    rst = 1'b1; st[0] = 1'b0; st[1] = 1'b0; we[0] = 1'b0; we[1] = 1'b0;
    waddr = '0; wdata = '0;
    mdv[0] = '0; mdv[1] = '0;
    do_rst();
    snap(0);
    snap(1);

    prog = {li(1, 5), li(2, 7), li(3, -2), enc(8'hAA, 4, 1, 2, 3), 32'hFF00_0000};
    program_run(0, 1'b0, 1'b0);

    prog = {li(1, 3), li(2, 4), li(3, 5), enc(8'hAB, 6, 1, 2, 3), sti(6, 2), 32'hFF00_0000};
    program_run(0, 1'b1, 1'b0);

    prog = {li(7, 9), 32'h5A00_0000, 32'hFF00_0000};
    program_run(0, 1'b0, 1'b0);
    run(0, 1'b0, 1'b0);

    // reset during EXEC of the TRIADD, then rerun the intact program
    prog = {li(1, 5), li(2, 7), li(3, -2), enc(8'hAA, 4, 1, 2, 3), 32'hFF00_0000};
    set_prog(0);
    load_all(0, 1'b0);
    st[0] = 1'b1; tick(); st[0] = 1'b0;
    repeat (7) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 32; i++) mx[0][i] = 0;
    mres[0] = '0;
    snap(0);
    run(0, 1'b0, 1'b0);

    prog = {32'h0, 32'h0, 32'h0, 32'h0};
    program_run(1, 1'b0, 1'b0);
    prog = {li(1, 100), li(2, 100), li(3, 100), 32'hFF00_0000};
    program_run(1, 1'b0, 1'b0);
    prog = {enc(8'hAA, 4, 1, 2, 3), li(5, -1), 32'hFF00_0000, 32'h0};
    program_run(1, 1'b1, 1'b0);

    for (int r = 0; r < 24; r++) begin
      int d = (r % 4 == 3) ? 1 : 0;
      prog = {};
      for (int i = 0; i < id(d); i++) prog.push_back(rnd_instr());
      program_run(d, r[0], (r % 3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tri_cpu.md
TRI_CPU -- requirements
Module: tri_cpu

Interface
REQ-001 Parameter XLEN, default 32: datapath and register width, legal range 8..32.
REQ-002 Parameter IMEM_DEPTH, default 16: instruction memory words (32-bit each), power of two, at least 4.
REQ-003 Parameter DMEM_DEPTH, default 16: data memory words (XLEN each), power of two.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port start, input, 1: begin execution at pc 0; sampled only in IDLE or HALT.
REQ-008 Port imem_we, input, 1: program-load write enable; ignored while busy.
REQ-009 Port imem_waddr, input, clog2(IMEM_DEPTH): program-load word address.
REQ-010 Port imem_wdata, input, 32: program-load instruction word.
REQ-011 Port dbg_raddr, input, 5: debug register read address.
REQ-012 Port dbg_rdata, output, XLEN: combinational value of x[dbg_raddr].
REQ-013 Port busy, output, 1: high in FETCH or EXEC.
REQ-014 Port done, output, 1: high in HALT.
REQ-015 Port illegal, output, 1: sticky flag for an undefined opcode or pc overrun; cleared on start or rst.
REQ-016 Port result_out, output, XLEN: last value written to any register or to dmem.
REQ-017 Port retired, output, 16: count of retired non-HALT instructions; wraps at 65535 -> 0.

Function
REQ-018 Instruction fields: [31:24] opcode, [23:19] rd, [18:14] rs1, [13:9] rs2, [8:4] rs3, [13:0] imm14.
REQ-019 Opcodes:
- 0x00 NOP: no effect.
- 0xAA TRIADD: x[rd] = x[rs1] + x[rs2] + x[rs3].
- 0xAB TRIMAC: x[rd] = x[rs1] * x[rs2] + x[rs3].
- 0xAC LI: x[rd] = sign-extended imm14.
- 0xAD ST: dmem[imm14 mod DMEM_DEPTH] = x[rs1].
- 0xFF HALT.
REQ-020 Arithmetic width: all results are truncated to their low XLEN bits with no overflow flag; the LI immediate is sign-extended, then truncated to XLEN.
REQ-021 Register file: 32 registers of XLEN bits; x0 always reads 0; writes to x0 are discarded, but result_out still updates.
REQ-022 State machine: states IDLE, FETCH, EXEC, HALT.
- IDLE/HALT with start=1 -> FETCH; at the same edge pc=0, retired=0, illegal=0.
- FETCH -> EXEC; the instruction register loads imem[pc].
- EXEC -> FETCH with pc+1, after the operation completes and retired increments.
- EXEC of HALT -> HALT, with no retired increment.
- EXEC of an undefined opcode -> HALT with illegal=1.
REQ-023 Timing: every non-HALT instruction takes exactly 2 cycles; register and dmem writes commit at the EXEC edge; operands read in EXEC see all earlier writes.
REQ-024 PC overrun: a non-HALT instruction retiring at pc=IMEM_DEPTH-1 -> HALT with illegal=1; pc never wraps.
REQ-025 Program load: imem_we writes imem[imem_waddr] in IDLE or HALT only.
REQ-026 Simultaneous load and start: if imem_we and start are both high, the write commits and the FETCH that follows reads the new word.
REQ-027 start is ignored while busy.
REQ-028 Debug read: dbg_rdata reflects register writes from the cycle after commit.

Reset
REQ-029 rst, at any state including mid-instruction, clears the following at the next edge:
- state -> IDLE, pc -> 0.
- all registers x1..x31 -> 0.
- busy, done, illegal -> 0.
- result_out -> 0, retired -> 0.
- Any in-flight EXEC write is suppressed.
REQ-030 rst leaves imem and dmem contents unchanged.
REQ-031 rst has priority over start and imem_we in the same cycle.

Verification
REQ-032 Program LI x1,5; LI x2,7; LI x3,-2; TRIADD x4,x1,x2,x3; HALT, then start -> done high 10 cycles after the start edge, result_out=10, dbg x4=10, retired=4, illegal=0.
REQ-033 With x1=3, x2=4, x3=5: TRIMAC x6,x1,x2,x3; ST x6 to dmem[2]; HALT -> x6=17, dmem[2]=17, result_out=17.
REQ-034 XLEN=8 with x1=x2=x3=100: TRIADD x4 -> x4=44 (300 mod 256); LI x5,-1 -> x5=0xFF.
REQ-035 Opcode 0x5A at pc 1 -> HALT after 4 cycles, illegal=1, retired=1; start again -> illegal clears.
REQ-036 IMEM_DEPTH=4 filled with NOPs, start -> HALT after 8 cycles, illegal=1, retired=4.
REQ-037 rst asserted during the EXEC of TRIADD x4 -> x4 stays 0, state IDLE, imem intact; start reruns the program to completion with correct results.
